// File: rtl/aes_decrypt_seq.sv
// aes_decrypt_seq: iterative AES-128/192/256 inverse cipher.
// The caller supplies the expanded key schedule already in decryption order;
// the block applies one or two inverse rounds per clock and hands the
// plaintext over a valid/ready pair. Completed blocks are counted.
// Optional build macro AES_DEC_SEG_EN drives h1/h2/h3 with the decimal value
// of the plaintext low byte; without it the digits are blanked.
module aes_decrypt_seq #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [1:0]       mode,
  input  logic [1919:0]    key_sched,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [CNT_W-1:0] blk_count,
  output logic [6:0]       h1,
  output logic [6:0]       h2,
  output logic [6:0]       h3
);

  generate
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_bad_rpc
      $error("aes_decrypt_seq: ROUNDS_PER_CYCLE must be 1 or 2");
    end
  endgenerate

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse S-box: undo the affine map, then take the field inverse as a^254
  // (zero maps to zero without a special case).
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    logic [7:0] sq;
    logic [7:0] r;
    a  = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    r  = 8'h01;
    sq = a;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
  // InvMixColumns unless this is the final round. Byte 0 is st[127:120],
  // bytes run down columns.
  function automatic logic [127:0] inv_round(input logic [127:0] st,
                                             input logic [127:0] rk,
                                             input logic         last);
    logic [7:0]   s    [16];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] res;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    // row r of output column c comes from column c-r of the input
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[4*c+r] = inv_sbox(st[127-8*(4*((c-r+4)%4)+r) -: 8]) ^ rk[127-8*(4*c+r) -: 8];
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (last) begin
          acc = s[4*c+r];
        end else begin
          acc = '0;
          for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(s[4*c+k], coef[(k-r+4)%4]);
        end
        res[127-8*(4*c+r) -: 8] = acc;
      end
    return res;
  endfunction

  logic [1:0]   fsm_q;
  logic [127:0] st_q;
  logic [127:0] st_next;
  logic [3:0]   idx_q;
  logic [3:0]   nr_q;
  logic [3:0]   rnd_idx;
  logic         fin;
  logic         load_out;

  assign in_ready = (fsm_q == IDLE);
  assign load_out = (fsm_q == RUN) && !flush && fin;

  // Chain ROUNDS_PER_CYCLE inverse rounds starting at the current index.
  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    st_next = st_q;
    fin     = 1'b0;
    rnd_idx = idx_q;
    for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      rnd_idx = idx_q + 4'(k);
      st_next = inv_round(st_next, key_sched[{rnd_idx, 7'd0} +: 128], rnd_idx == nr_q);
      if (rnd_idx == nr_q) fin = 1'b1;
    end
  end

  // Control FSM, round state, output register and block counter.
  // NOTE: datapath registers are reset too, so no stale key material survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      st_q      <= '0;
      idx_q     <= '0;
      nr_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      blk_count <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge.
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            nr_q  <= (mode == 2'b00) ? 4'd10 : (mode == 2'b01) ? 4'd12 : 4'd14;
            st_q  <= in_data ^ key_sched[127:0];
            idx_q <= 4'd1;
            fsm_q <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            fsm_q <= IDLE;
          end else begin
            st_q  <= st_next;
            idx_q <= idx_q + 4'(ROUNDS_PER_CYCLE);
            if (fin) begin
              out_data  <= st_next;
              out_valid <= 1'b1;
              fsm_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (flush) begin
            out_valid <= 1'b0;
            fsm_q     <= IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            blk_count <= blk_count + 1'b1;
            fsm_q     <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

`ifdef AES_DEC_SEG_EN
  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  logic [7:0] lo_byte;
  assign lo_byte = st_next[7:0];

  // Digits follow out_data: refreshed in the same edge that loads the plaintext.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1 <= 7'h40;
      h2 <= 7'h40;
      h3 <= 7'h40;
    end else if (load_out) begin
      h1 <= seg7(4'(lo_byte / 8'd100));
      h2 <= seg7(4'((lo_byte / 8'd10) % 8'd10));
      h3 <= seg7(4'(lo_byte % 8'd10));
    end
  end
`else
  logic unused_load;
  assign unused_load = load_out;
  assign h1 = 7'h7F;
  assign h2 = 7'h7F;
  assign h3 = 7'h7F;
`endif

endmodule

// File: tb/tb_aes_decrypt_seq.sv
// tb_aes_decrypt_seq: two instances (one and two rounds per cycle, the second
// with a 2-bit block counter) driven from shared stimulus. The driver pushes
// expected plaintext and due cycle per block; per-instance monitors pop and
// compare when out_valid rises. Round keys are expanded here from the
// FIPS-197 appendix C cipher keys.
module tb_aes_decrypt_seq;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

`ifdef AES_DEC_SEG_EN
  localparam logic [6:0] SEG_RST = 7'h40;
  localparam logic [6:0] SEG_H   = 7'h24;
  localparam logic [6:0] SEG_T   = 7'h12;
  localparam logic [6:0] SEG_U   = 7'h12;
`else
  localparam logic [6:0] SEG_RST = 7'h7F;
  localparam logic [6:0] SEG_H   = 7'h7F;
  localparam logic [6:0] SEG_T   = 7'h7F;
  localparam logic [6:0] SEG_U   = 7'h7F;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b1;
  logic [127:0]  in_data = '0;
  logic [1:0]    mode = '0;
  logic [1919:0] key_sched = '0;

  logic in_ready1, in_ready2, ov1, ov2;
  logic [127:0] od1, od2;
  logic [15:0]  cnt1;
  logic [1:0]   cnt2;
  logic [6:0]   h1a, h2a, h3a, h1b, h2b, h3b;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];
  exp_t e1, e2;
  logic ov1_q = 1'b0;
  logic ov2_q = 1'b0;

  logic [1919:0] ks128, ks192, ks256;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_decrypt_seq #(.ROUNDS_PER_CYCLE(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .mode(mode), .key_sched(key_sched), .flush(flush),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .blk_count(cnt1),
    .h1(h1a), .h2(h2a), .h3(h3a)
  );

  aes_decrypt_seq #(.ROUNDS_PER_CYCLE(2), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .mode(mode), .key_sched(key_sched), .flush(flush),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .blk_count(cnt2),
    .h1(h1b), .h2(h2b), .h3(h3b)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- key expansion (forward S-box built from a brute-force field inverse)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Returns the schedule in decryption order: slot i holds encryption round key nr-i.
  function automatic logic [1919:0] make_ks(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rcon = 8'h01;
    logic [1919:0] ks = '0;
    int nr = nk + 6;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      ks[128*(nr-r) +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  // ---- monitors: compare each new output against the head of its queue
  always @(negedge clk) begin
    if (ov1 && !ov1_q) begin
      check("dut1 output expected", 128'(sb1.size() > 0), 128'd1);
      if (sb1.size() > 0) begin
        e1 = sb1.pop_front();
        check("dut1 plaintext", od1, e1.data);
        check("dut1 latency", 128'(cyc), 128'(e1.due));
      end
    end
    ov1_q <= ov1;
  end

  always @(negedge clk) begin
    if (ov2 && !ov2_q) begin
      check("dut2 output expected", 128'(sb2.size() > 0), 128'd1);
      if (sb2.size() > 0) begin
        e2 = sb2.pop_front();
        check("dut2 plaintext", od2, e2.data);
        check("dut2 latency", 128'(cyc), 128'(e2.due));
      end
    end
    ov2_q <= ov2;
  end

  // ---- driver
  task automatic send(input logic [127:0] ct, input logic [1:0] md, input logic [1919:0] ks,
                      input int nr, input bit expect_out, input bit flush_at_accept);
    exp_t e;
    @(negedge clk);
    check("accept ready", {126'd0, in_ready1, in_ready2}, 128'd3);
    in_data   = ct;
    mode      = md;
    key_sched = ks;
    in_valid  = 1'b1;
    flush     = flush_at_accept;
    @(posedge clk);
    #1;
    if (expect_out) begin
      e.data = PT;
      e.due  = cyc + nr;
      sb1.push_back(e);
      e.due  = cyc + nr / 2;
      sb2.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(in_ready1 && in_ready2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(in_ready1 && in_ready2), 128'd1);
  endtask

  task automatic check_counts(input string name, input int c1, input int c2);
    check({name, " cnt1"}, 128'(cnt1), 128'(c1));
    check({name, " cnt2"}, 128'(cnt2), 128'(c2));
  endtask

  initial begin
    int n;
    ks128 = make_ks({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    ks192 = make_ks({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    ks256 = make_ks(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    // reset state
    repeat (3) @(negedge clk);
    check("rst out_valid", {126'd0, ov1, ov2}, 128'd0);
    check("rst out_data1", od1, 128'd0);
    check("rst out_data2", od2, 128'd0);
    check_counts("rst", 0, 0);
    check("rst seg", {86'd0, h1a, h2a, h3a, h1b, h2b, h3b},
          {86'd0, SEG_RST, SEG_RST, SEG_RST, SEG_RST, SEG_RST, SEG_RST});
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after release", {126'd0, in_ready1, in_ready2}, 128'd3);

    // C.1, C.2, C.3 vectors with free-flowing output
    send(CT1, 2'b00, ks128, 10, 1'b1, 1'b0);
    wait_idle("v1 idle");
    check_counts("v1", 1, 1);
    send(CT2, 2'b01, ks192, 12, 1'b1, 1'b0);
    wait_idle("v2 idle");
    check_counts("v2", 2, 2);
    send(CT3, 2'b11, ks256, 14, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    mode = 2'b00;
    @(negedge clk);
    mode = 2'b01;
    wait_idle("v3 idle");
    mode = 2'b00;
    check_counts("v3", 3, 3);

    // back-pressure: hold out_ready low for 5 cycles once both are in DONE
    out_ready = 1'b0;
    send(CT1, 2'b00, ks128, 10, 1'b1, 1'b0);
    n = 0;
    while (!ov1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall valid", 128'(ov1), 128'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall hold valid", {126'd0, ov1, ov2}, 128'd3);
      check("stall hold data1", od1, PT);
      check("stall hold data2", od2, PT);
      check("stall not ready", {126'd0, in_ready1, in_ready2}, 128'd0);
      check_counts("stall", 3, 3);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release valid low", {126'd0, ov1, ov2}, 128'd0);
    check("release ready", {126'd0, in_ready1, in_ready2}, 128'd3);
    check_counts("release", 4, 0);

    // flush at the accept edge is ignored while idle
    send(CT2, 2'b01, ks192, 12, 1'b1, 1'b1);
    wait_idle("idle flush ignored");
    check_counts("idle flush", 5, 1);

    // flush in DONE beats out_ready: no count
    out_ready = 1'b0;
    send(CT1, 2'b00, ks128, 10, 1'b1, 1'b0);
    n = 0;
    while (!ov1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done flush valid", 128'(ov1), 128'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("done flush valid low", {126'd0, ov1, ov2}, 128'd0);
    check("done flush ready", {126'd0, in_ready1, in_ready2}, 128'd3);
    check_counts("done flush", 5, 1);

    // flush at RUN cycle 4
    send(CT1, 2'b00, ks128, 10, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("run flush ready", {126'd0, in_ready1, in_ready2}, 128'd3);
    check("run flush data1 kept", od1, PT);
    check("run flush data2 kept", od2, PT);
    check_counts("run flush", 5, 1);
    for (int i = 0; i < 12; i++) begin
      check("run flush no valid", {126'd0, ov1, ov2}, 128'd0);
      @(negedge clk);
    end

    // reset at RUN cycle 3
    send(CT1, 2'b00, ks128, 10, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset valid", {126'd0, ov1, ov2}, 128'd0);
    check("mid reset data1", od1, 128'd0);
    check_counts("mid reset", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid reset ready", {126'd0, in_ready1, in_ready2}, 128'd3);
    for (int i = 0; i < 16; i++) begin
      check("mid reset no valid", {126'd0, ov1, ov2}, 128'd0);
      @(negedge clk);
    end

    // recovery and seven-segment digits for low byte 0xff
    send(CT2, 2'b01, ks192, 12, 1'b1, 1'b0);
    wait_idle("recover idle");
    check_counts("recover", 1, 1);
    check("seg digits", {86'd0, h1a, h2a, h3a, h1b, h2b, h3b},
          {86'd0, SEG_H, SEG_T, SEG_U, SEG_H, SEG_T, SEG_U});
    check("sb drained", 128'(sb1.size() + sb2.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_seq.md
AES_DECRYPT_SEQ -- requirements
Module: aes_decrypt_seq

Interface
REQ-001 SHALL declare parameter ROUNDS_PER_CYCLE, default 1, meaning inverse rounds evaluated per clock; legal values 1 or 2; any other value SHALL fail elaboration.
REQ-002 SHALL declare parameter CNT_W, default 16, meaning width of the completed-block counter.
REQ-003 SHALL declare port clk, input, 1, the single clock; all state is rising-edge.
REQ-004 SHALL declare port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL declare port in_valid, input, 1, ciphertext and mode valid.
REQ-006 SHALL declare port in_ready, output, 1, block can accept a new ciphertext.
REQ-007 SHALL declare port in_data, input, 128, ciphertext block.
REQ-008 SHALL declare port mode, input, 2, key length: 00 = 128-bit (nr=10), 01 = 192-bit (nr=12), 10 or 11 = 256-bit (nr=14).
REQ-009 SHALL declare port key_sched, input, 1920, round keys in decryption order; round key i = key_sched[128*i +: 128], i = 0..nr.
REQ-010 SHALL declare port flush, input, 1, synchronous abort of the block in flight.
REQ-011 SHALL declare port out_valid, output, 1, plaintext valid.
REQ-012 SHALL declare port out_ready, input, 1, consumer accepts plaintext.
REQ-013 SHALL declare port out_data, output, 128, plaintext block.
REQ-014 SHALL declare port blk_count, output, CNT_W, number of delivered plaintext blocks.
REQ-015 SHALL declare ports h1, h2, h3, output, 7 each, active-low seven-segment digits.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE.
REQ-018 On IDLE with in_valid=1: SHALL latch nr from mode, load state <= in_data ^ round key 0, set round index <= 1, and enter RUN.
REQ-019 In RUN: SHALL apply ROUNDS_PER_CYCLE consecutive rounds per cycle, each using round key at the current index: full inverse round for indexes 1..nr-1, last inverse round (no InvMixColumns) at index nr.
REQ-020 SHALL advance the round index by ROUNDS_PER_CYCLE per RUN cycle; on the cycle that applies index nr, SHALL load out_data and enter DONE.
REQ-021 SHALL assert out_valid on the edge exactly nr/ROUNDS_PER_CYCLE cycles after the accept edge: 10/12/14 cycles for ROUNDS_PER_CYCLE=1, 5/6/7 cycles for 2.
REQ-022 SHALL sample mode and key_sched only through the latched nr and per-cycle key selection; mode changes after accept SHALL NOT affect the block in flight.
REQ-023 In DONE: SHALL hold out_valid=1 and out_data stable until out_ready=1, then return to IDLE and clear out_valid on that edge.
REQ-024 SHALL increment blk_count on each out_valid && out_ready edge, wrapping from all-ones to 0.
REQ-025 flush=1 in RUN or DONE SHALL return the FSM to IDLE on the next edge with out_valid=0 and blk_count unchanged; flush in IDLE SHALL be ignored; flush SHALL take priority over in_valid and out_ready.
REQ-026 out_data SHALL retain its last value after leaving DONE.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, out_valid=0, out_data=0, blk_count=0, round index=0, internal state=0; in_ready=1 on the first edge after release.
REQ-028 Reset asserted mid-RUN SHALL discard the block with no out_valid pulse.

Configuration
REQ-029 With AES_DEC_SEG_EN defined: h1/h2/h3 SHALL show out_data[7:0] as decimal hundreds/tens/units, updated when out_data loads; digits SHALL show 0 during reset.
REQ-030 Without AES_DEC_SEG_EN: h1, h2, h3 SHALL be constant 7'h7F (all segments off) and no decoder logic SHALL be synthesised.

Verification
REQ-031 mode=00, FIPS-197 C.1 schedule, in_data=69c4e0d86a7b0430d8cdb78070b4c55a, ROUNDS_PER_CYCLE=1 -> out_data=00112233445566778899aabbccddeeff, out_valid 10 cycles after accept.
REQ-032 mode=01, C.2 schedule, in_data=dda97ca4864cdfe06eaf70a0ec0d7191, ROUNDS_PER_CYCLE=2 -> same plaintext, out_valid 6 cycles after accept.
REQ-033 mode=11, C.3 schedule, in_data=8ea2b7ca516745bfeafc49904b496089 -> same plaintext after 14 cycles; mode toggled mid-RUN has no effect.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, blk_count unchanged until release, then +1.
REQ-035 flush pulse at RUN cycle 4, and separately rst_n=0 at RUN cycle 3 -> no out_valid pulse; in_ready=1 next cycle; blk_count unchanged.
REQ-036 With AES_DEC_SEG_EN and plaintext low byte 0xff -> h1/h2/h3 encode 2, 5, 5; without the macro -> all 7'h7F.
